// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: constants, opcodes and the {pc,instr} entry type shared by fetch, decode and later stages
package fetch_unit_pkg;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;
  function automatic logic [31:0] word_align(input logic [31:0] a);
    return a & ~32'h3;
  endfunction
endpackage

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: instruction-memory, redirect and decoder-side signals of the fetch stage
interface fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  modport master (
    output imem_req, imem_addr, out_valid, out_instr, out_pc,
    input  imem_gnt, imem_rvalid, imem_rdata, redirect_valid, redirect_pc, out_ready
  );
  modport slave (
    input  imem_req, imem_addr, out_valid, out_instr, out_pc,
    output imem_gnt, imem_rvalid, imem_rdata, redirect_valid, redirect_pc, out_ready
  );
endinterface

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous prefetch FIFO of {pc,instr} entries with flush; head is read straight from storage
module fetch_fifo import fetch_unit_pkg::*; #(
  parameter int           DEPTH     = 2,
  parameter fetch_entry_t RESET_VAL = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_push,
  input  logic                   i_pop,
  input  logic                   i_flush,
  input  fetch_entry_t           i_data,
  output fetch_entry_t           o_data,
  output logic [$clog2(DEPTH):0] o_count,
  output logic                   o_full,
  output logic                   o_empty
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  fetch_entry_t  r_mem [DEPTH];
  logic [PW-1:0] r_wr, r_rd;
  logic [CW-1:0] r_count;
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= RESET_VAL;
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (i_push) begin
        r_mem[r_wr] <= i_data;
        r_wr        <= r_wr + PW'(1);
      end
      if (i_pop) r_rd <= r_rd + PW'(1);
      r_count <= r_count + CW'(i_push) - CW'(i_pop);
    end
  end
  assign o_data  = r_mem[r_rd];
  assign o_count = r_count;
  assign o_full  = r_count == CW'(DEPTH);
  assign o_empty = r_count == '0;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: owns the PC, issues in-order imem reads under a slot-credit rule and feeds {pc,instr} to the decoder
module fetch_unit import fetch_unit_pkg::*; #(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEF,
  parameter int          FIFO_DEPTH = 2,
  parameter int          MAX_OUTST  = 2
) (
  input logic          clk,
  input logic          rst,
  fetch_unit_if.master io_bus
);
  localparam int OW = $clog2(MAX_OUTST + 1);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam fetch_entry_t RESET_ENTRY = {RESET_PC, NOP_INSTR};
  logic [31:0]   r_fetch_pc, r_resp_pc, w_used, w_target;
  logic [OW-1:0] r_outst, r_discard;
  logic [CW-1:0] w_count;
  logic          w_empty, w_full, w_pop, w_rv, w_push, w_issue, w_redir;
  fetch_entry_t  w_in, w_head;
  assign w_redir  = io_bus.redirect_valid;
  assign w_target = word_align(io_bus.redirect_pc);
  assign w_pop    = !w_empty && io_bus.out_ready;
  assign w_rv     = io_bus.imem_rvalid && r_outst != '0;
  assign w_push   = w_rv && r_discard == '0 && !w_redir && (!w_full || w_pop);
  // a head leaving this cycle frees its slot, which keeps k=1 streaming at one word per cycle
  assign w_used   = 32'(w_count) + 32'(r_outst) - 32'(w_pop);
  assign io_bus.imem_req  = !rst && !w_redir && r_outst < OW'(MAX_OUTST) && w_used < 32'(FIFO_DEPTH);
  assign io_bus.imem_addr = r_fetch_pc;
  assign w_issue = io_bus.imem_req && io_bus.imem_gnt;
  assign w_in    = {r_resp_pc, io_bus.imem_rdata};
  assign io_bus.out_valid = !w_empty;
  assign io_bus.out_pc    = w_head.pc;
  assign io_bus.out_instr = w_head.instr;
  fetch_fifo #(.DEPTH(FIFO_DEPTH), .RESET_VAL(RESET_ENTRY)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (w_redir),
    .i_data  (w_in),
    .o_data  (w_head),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );
  // after a redirect every request still in flight belongs to the old stream
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_pc <= RESET_PC;
      r_resp_pc  <= RESET_PC;
      r_outst    <= '0;
      r_discard  <= '0;
    end else if (w_redir) begin
      r_fetch_pc <= w_target;
      r_resp_pc  <= w_target;
      r_outst    <= r_outst - OW'(w_rv);
      r_discard  <= r_outst - OW'(w_rv);
    end else begin
      if (w_issue) r_fetch_pc <= r_fetch_pc + 32'd4;
      if (w_push) r_resp_pc <= r_resp_pc + 32'd4;
      r_outst <= r_outst + OW'(w_issue) - OW'(w_rv);
      if (w_rv && r_discard != '0) r_discard <= r_discard - OW'(1);
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed and random fetch traffic checked against a program-order model of the fetch stream
module tb_fetch_unit;
  import fetch_unit_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  fetch_unit_if b0 ();
  fetch_unit_if b1 ();
  fetch_unit #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(2), .MAX_OUTST(2)) u0 (.clk(clk), .rst(rst), .io_bus(b0));
  fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .FIFO_DEPTH(2), .MAX_OUTST(2)) u1 (.clk(clk), .rst(rst), .io_bus(b1));
  int checks = 0, failures = 0, held = 0, xfers = 0;
  int gnt_pct = 0, rv_pct = 0, rdy_pct = 0;
  bit redir = 0, force_rv = 0, prev_hold = 0, prev_wait = 0;
  logic [31:0] redir_pc = '0, exp_pc = '0, exp_fetch = '0, prev_instr = '0, last_pc = '0;
  logic [31:0] pa [$];
  bit          ps [$];
  logic [31:0] q1 [$];
  logic [31:0] wexp, wout;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    logic [31:0] n;
    n = (a >> 2) + 32'd1;
    return ((n * 32'd5) << 20) | ((n & 32'd31) << 7) | 32'h13;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    bit rv, iss, xf;
    @(negedge clk);
    b0.imem_gnt       = $urandom_range(99) < gnt_pct;
    rv                = force_rv || (pa.size() > 0 && $urandom_range(99) < rv_pct);
    b0.imem_rvalid    = rv;
    b0.imem_rdata     = pa.size() > 0 ? word_at(pa[0]) : 32'hDEAD_BEEF;
    b0.out_ready      = $urandom_range(99) < rdy_pct;
    b0.redirect_valid = redir;
    b0.redirect_pc    = redir_pc;
    #1;
    if (rst) begin
      pa.delete(); ps.delete();
      held = 0; exp_pc = 32'h0; exp_fetch = 32'h0; prev_hold = 0; prev_wait = 0;
    end else begin
      chk("out_valid", {31'b0, b0.out_valid}, {31'b0, held > 0});
      chk("addr_align", {30'b0, b0.imem_addr[1:0]}, 32'h0);
      if (redir) chk("req_in_redirect", {31'b0, b0.imem_req}, 32'h0);
      if (prev_wait && !redir) chk("req_stable", {31'b0, b0.imem_req}, 32'h1);
      if (prev_hold && !redir) chk("instr_stable", b0.out_instr, prev_instr);
      iss = b0.imem_req && b0.imem_gnt;
      xf  = b0.out_valid && b0.out_ready;
      if (xf) begin
        chk("out_pc", b0.out_pc, exp_pc);
        chk("out_instr", b0.out_instr, word_at(exp_pc));
        last_pc = b0.out_pc;
        exp_pc += 32'd4;
        held--;
        xfers++;
      end
      if (iss) chk("imem_addr", b0.imem_addr, exp_fetch);
      if (rv && pa.size() > 0) begin
        if (!ps[0] && !redir) held++;
        void'(pa.pop_front());
        void'(ps.pop_front());
      end
      if (redir) begin
        held = 0;
        foreach (ps[i]) ps[i] = 1'b1;
        exp_pc    = redir_pc & ~32'h3;
        exp_fetch = exp_pc;
      end
      if (iss) begin
        pa.push_back(exp_fetch);
        ps.push_back(1'b0);
        exp_fetch += 32'd4;
      end
      chk("credit", {31'b0, held + pa.size() <= 2}, 32'h1);
      prev_hold  = b0.out_valid && !b0.out_ready && !redir;
      prev_instr = b0.out_instr;
      prev_wait  = b0.imem_req && !b0.imem_gnt && !redir;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; redir = 0; force_rv = 0;
    cyc(); cyc();
    @(posedge clk); #1;
    chk("rst_out_valid", {31'b0, b0.out_valid}, 32'h0);
    chk("rst_out_instr", b0.out_instr, NOP_INSTR);
    chk("rst_out_pc", b0.out_pc, 32'h0);
    chk("rst_req", {31'b0, b0.imem_req}, 32'h0);
    chk("rst_wrap_out_pc", b1.out_pc, 32'hFFFF_FFF8);
    rst = 1'b0; #1;
    chk("first_req", {31'b0, b0.imem_req}, 32'h1);
    chk("first_addr", b0.imem_addr, 32'h0);
  endtask

  task automatic await_first(input string tag, input logic [31:0] target);
    xfers = 0; last_pc = 32'hFFFF_FFFF;
    for (int i = 0; i < 20 && xfers == 0; i++) cyc();
    chk(tag, last_pc, target);
  endtask

  initial begin
    b0.imem_gnt = 0; b0.imem_rvalid = 0; b0.imem_rdata = 0; b0.redirect_valid = 0; b0.redirect_pc = 0; b0.out_ready = 0;
    b1.imem_gnt = 0; b1.imem_rvalid = 0; b1.imem_rdata = 0; b1.redirect_valid = 0; b1.redirect_pc = 0; b1.out_ready = 0;
    do_reset();
    gnt_pct = 100; rv_pct = 100; rdy_pct = 100;
    repeat (4) cyc();
    xfers = 0;
    repeat (12) cyc();
    chk("throughput", xfers, 32'd12);
    rdy_pct = 0;
    repeat (20) cyc();
    chk("bp_req_low", {31'b0, b0.imem_req}, 32'h0);
    chk("bp_full_valid", {31'b0, b0.out_valid}, 32'h1);
    rdy_pct = 100; gnt_pct = 70; rv_pct = 70;
    repeat (30) cyc();
    gnt_pct = 100; rv_pct = 0;
    for (int i = 0; i < 20 && pa.size() < 2; i++) cyc();
    chk("two_in_flight", pa.size(), 32'd2);
    redir = 1; redir_pc = 32'h0000_0103;
    cyc();
    redir = 0;
    cyc();
    chk("redir_next_addr", b0.imem_addr, 32'h0000_0100);
    chk("redir_valid_low", {31'b0, b0.out_valid}, 32'h0);
    rv_pct = 100;
    await_first("redir_first_pc", 32'h0000_0100);
    repeat (6) cyc();
    redir = 1; redir_pc = 32'h0000_0200;
    cyc();
    redir = 0;
    await_first("redir_rv_first_pc", 32'h0000_0200);
    repeat (6) cyc();
    gnt_pct = 0; rv_pct = 0;
    repeat (3) cyc();
    redir = 1; redir_pc = 32'h0000_0302;
    cyc();
    redir = 0; gnt_pct = 100; rv_pct = 100;
    await_first("redir_stall_first_pc", 32'h0000_0300);
    gnt_pct = 60; rv_pct = 60; rdy_pct = 70;
    repeat (400) begin
      redir    = $urandom_range(99) < 5;
      redir_pc = $urandom;
      cyc();
    end
    redir = 0; gnt_pct = 100; rv_pct = 50; rdy_pct = 100;
    repeat (5) cyc();
    do_reset();
    gnt_pct = 0; force_rv = 1;
    cyc();
    force_rv = 0;
    cyc();
    gnt_pct = 100; rv_pct = 100;
    await_first("post_reset_first_pc", 32'h0000_0000);
    repeat (8) cyc();
    do_reset();
    b1.imem_gnt = 1; b1.out_ready = 1;
    wexp = 32'hFFFF_FFF8; wout = 32'hFFFF_FFF8;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      b1.imem_rvalid = q1.size() > 0;
      b1.imem_rdata  = q1.size() > 0 ? word_at(q1[0]) : 32'h0;
      #1;
      if (b1.imem_req) begin
        chk("wrap_addr", b1.imem_addr, wexp);
        q1.push_back(wexp);
        wexp += 32'd4;
      end
      if (b1.out_valid) begin
        chk("wrap_out_pc", b1.out_pc, wout);
        chk("wrap_out_instr", b1.out_instr, word_at(wout));
        wout += 32'd4;
      end
      if (b1.imem_rvalid) void'(q1.pop_front());
    end
    chk("wrap_out_count", wout, 32'h0000_0010);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
